fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 19, PC and instruction-address width.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, instruction-queue entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have parameter PC_STEP, default 1, sequential PC increment.
REQ-006 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port enable, input, 1, allows new fetch issue and PC advance.
REQ-009 SHALL have port redirect_valid, input, 1, branch/jump taken this cycle.
REQ-010 SHALL have port redirect_pc, input, PC_WIDTH, redirect target.
REQ-011 SHALL have port imem_req, output, 1, instruction-memory read strobe.
REQ-012 SHALL have port imem_addr, output, PC_WIDTH, read address; equals the current PC.
REQ-013 SHALL have port imem_data, input, INSTRUCTION_WIDTH, read data, valid exactly one cycle after an imem_req cycle.
REQ-014 SHALL have port out_valid, output, 1, queue head holds an instruction.
REQ-015 SHALL have port out_ready, input, 1, decode accepts the head.
REQ-016 SHALL have port out_instruction, output, INSTRUCTION_WIDTH, head instruction.
REQ-017 SHALL have port out_pc, output, PC_WIDTH, PC of the head instruction.
REQ-018 SHALL have port count, output, $clog2(DEPTH+1), queue occupancy.

Function
REQ-019 SHALL define dequeue as out_valid && out_ready; out_instruction/out_pc SHALL hold stable while out_valid && !out_ready.
REQ-020 SHALL assert imem_req when enable && !redirect_valid && (count + inflight - dequeue) < DEPTH; inflight is 1 if imem_req was high last cycle and not cancelled.
REQ-021 SHALL advance PC to PC + PC_STEP, modulo 2^PC_WIDTH, on each imem_req cycle; otherwise hold PC.
REQ-022 SHALL write {imem_data, issuing PC} into the queue tail in the response cycle when inflight is 1; out_valid SHALL rise no earlier than the next cycle (no bypass).
REQ-023 SHALL capture an in-flight response even when enable is 0; enable=0 SHALL NOT block dequeue.
REQ-024 SHALL, on redirect_valid (regardless of enable): load PC with redirect_pc, empty the queue (count=0, out_valid=0 next cycle), cancel any in-flight response, and suppress imem_req that cycle.
REQ-025 SHALL give redirect priority over a simultaneous dequeue, write, or issue; a dequeue in the redirect cycle is still a valid handshake for decode.
REQ-026 SHALL sustain one instruction per cycle with out_ready held high when DEPTH >= 2.
REQ-027 SHALL support simultaneous write and dequeue at any occupancy, count unchanged; the credit rule in REQ-020 SHALL guarantee no write to a full queue.
REQ-028 SHALL meet latency: redirect sampled at edge T gives imem_req with redirect_pc in cycle T+1 and out_valid with out_pc=redirect_pc in cycle T+3.
REQ-029 SHALL wrap queue read/write pointers modulo DEPTH.

Reset
REQ-030 SHALL, while reset is high, set PC=RESET_PC, count=0, inflight=0, pointers=0, out_valid=0, imem_req=0.
REQ-031 SHALL issue the first fetch (imem_addr=RESET_PC) in the first cycle after reset deasserts, if enable is 1.
REQ-032 SHALL discard in-flight data and queue contents on reset asserted mid-operation.

Structure
REQ-033 SHALL place default parameter values and a fetch_entry_t struct {pc, instruction} in package fetch_pkg.
REQ-034 SHALL implement the queue as sub-module fetch_fifo (synchronous flush, push, pop, count).

Verification
REQ-035 SHALL cover: reset release, enable=1, out_ready=1, imem_data=addr*16 -> out_pc 0,1,2,3 on consecutive cycles from cycle 3 on, out_instruction 0x00,0x10,0x20,0x30.
REQ-036 SHALL cover: out_ready=0 for 10 cycles -> count saturates at 4, imem_req low once full, PC holds at 4, no entry lost or duplicated after out_ready=1.
REQ-037 SHALL cover: redirect_valid with redirect_pc=0x100 while count=3 and a fetch is in flight -> count=0 next cycle, imem_addr=0x100 next cycle, first out_pc=0x100 at T+3, stale data never appears.
REQ-038 SHALL cover: PC=0x7FFFF with PC_STEP=1 -> next fetch address 0x00000.
REQ-039 SHALL cover: enable dropped in the cycle after an issue -> that response is still queued, no new imem_req, PC frozen until enable=1.
REQ-040 SHALL cover: reset asserted with count=2 -> out_valid=0, count=0 next cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared defaults and the queue entry layout for the instruction fetch unit.
package fetch_pkg;
  localparam int          FETCH_PC_WIDTH          = 19;
  localparam int          FETCH_INSTRUCTION_WIDTH = 32;
  localparam int          FETCH_DEPTH             = 4;
  localparam int unsigned FETCH_RESET_PC          = 0;
  localparam int unsigned FETCH_PC_STEP           = 1;

  typedef struct packed {
    logic [FETCH_PC_WIDTH-1:0]          pc;
    logic [FETCH_INSTRUCTION_WIDTH-1:0] instruction;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: power-of-two ring buffer with synchronous flush,
// simultaneous push/pop at any occupancy, and a registered head (no bypass).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = FETCH_DEPTH,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  assign valid  = (count != '0);
  assign pop_ok = pop && valid;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, single-cycle memory read issue under a
// credit check, and an instruction queue feeding decode; redirects flush all.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          PC_WIDTH          = FETCH_PC_WIDTH,
  parameter int          INSTRUCTION_WIDTH = FETCH_INSTRUCTION_WIDTH,
  parameter int          DEPTH             = FETCH_DEPTH,
  parameter int unsigned RESET_PC          = FETCH_RESET_PC,
  parameter int unsigned PC_STEP           = FETCH_PC_STEP,
  localparam int         CNT_W             = $clog2(DEPTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH-1:0]          redirect_pc,
  output logic                         imem_req,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic [CNT_W-1:0]             count
);

  typedef logic [PC_WIDTH-1:0] pc_t;
  typedef logic [CNT_W:0]      credit_t;
  typedef struct packed {
    logic [PC_WIDTH-1:0]          pc;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
  } entry_t;

  pc_t     pc;
  pc_t     issue_pc;
  logic    inflight;
  logic    dequeue;
  logic    push;
  credit_t credit;
  entry_t  push_entry;
  entry_t  head;

  assign dequeue = out_valid && out_ready;

  // Occupancy the queue will need once the outstanding read lands; never
  // underflows because a dequeue implies at least one entry.
  assign credit   = credit_t'(count) + credit_t'(inflight) - credit_t'(dequeue);
  assign imem_req = !reset && enable && !redirect_valid && (credit < credit_t'(DEPTH));
  assign imem_addr = pc;

  assign push       = inflight && !redirect_valid;
  assign push_entry = '{pc: issue_pc, instruction: imem_data};

  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= pc_t'(RESET_PC);
      issue_pc <= '0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc       <= pc + pc_t'(PC_STEP);
        issue_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (dequeue),
    .head      (head),
    .valid     (out_valid),
    .count     (count)
  );

  assign out_instruction = head.instruction;
  assign out_pc          = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; instruction memory returns addr*16 one cycle
// after each read strobe, and junk otherwise.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        redirect_valid;
  logic [18:0] redirect_pc;
  logic        imem_req;
  logic [18:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [18:0] out_pc;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  logic        req_q;
  logic [18:0] addr_q;

  int cnt_tab [10] = '{0, 0, 1, 2, 3, 4, 4, 4, 4, 4};

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .count           (count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) begin
    req_q  = imem_req;
    addr_q = imem_addr;
  end

  function automatic logic [31:0] mk(input logic [18:0] a);
    return {9'b0, a, 4'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    imem_data = req_q ? mk(addr_q) : 32'hBAD0_BAD0;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b0; imem_data = 32'hBAD0_BAD0;
    tick(); tick();
    settle();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);

    // Streaming from reset release
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    settle();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'd0);
    check("c1_valid", 32'(out_valid), 32'd0);
    tick(); settle();
    check("c2_req", 32'(imem_req), 32'd1);
    check("c2_addr", 32'(imem_addr), 32'd1);
    check("no_bypass", 32'(out_valid), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      settle();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_pc", 32'(out_pc), 32'(i));
      check("stream_instr", out_instruction, 32'(i * 16));
      tick();
    end

    // Back-pressure: fill to DEPTH, then drain without loss or duplication
    reset = 1'b1; tick();
    reset = 1'b0; out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      settle();
      check("stall_count", 32'(count), 32'(cnt_tab[k-1]));
      check("stall_req", 32'(imem_req), (k <= 4) ? 32'd1 : 32'd0);
      if (k >= 3) check("stall_hold_pc", 32'(out_pc), 32'd0);
      if (k == 10) check("stall_pc", 32'(imem_addr), 32'd4);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_pc", 32'(out_pc), 32'(i));
      check("drain_instr", out_instruction, 32'(i * 16));
      tick();
    end

    // Redirect with count=3 and a read outstanding
    reset = 1'b1; out_ready = 1'b0; tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 19'h100;
    settle();
    check("redir_pre_count", 32'(count), 32'd3);
    check("redir_suppress", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    settle();
    check("redir_count", 32'(count), 32'd0);
    check("redir_valid", 32'(out_valid), 32'd0);
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", 32'(imem_addr), 32'h100);
    tick(); settle();
    check("redir_t2_valid", 32'(out_valid), 32'd0);
    check("redir_t2_addr", 32'(imem_addr), 32'h101);
    tick(); settle();
    check("redir_t3_valid", 32'(out_valid), 32'd1);
    check("redir_t3_pc", 32'(out_pc), 32'h100);
    check("redir_t3_instr", out_instruction, 32'h1000);
    tick(); settle();
    check("redir_t4_pc", 32'(out_pc), 32'h101);
    check("redir_t4_instr", out_instruction, 32'h1010);
    tick();

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 19'h7FFFF;
    settle(); tick();
    redirect_valid = 1'b0;
    settle();
    check("wrap_addr_top", 32'(imem_addr), 32'h7FFFF);
    tick(); settle();
    check("wrap_req", 32'(imem_req), 32'd1);
    check("wrap_addr_zero", 32'(imem_addr), 32'd0);
    tick(); settle();
    check("wrap_out_pc", 32'(out_pc), 32'h7FFFF);
    check("wrap_out_instr", out_instruction, 32'h007F_FFF0);
    tick(); settle();
    check("wrap_next_pc", 32'(out_pc), 32'd0);
    tick();

    // Enable dropped right after an issue
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 19'h200;
    settle(); tick();
    redirect_valid = 1'b0;
    settle();
    check("en_issue_addr", 32'(imem_addr), 32'h200);
    tick();
    enable = 1'b0;
    settle();
    check("en_off_req", 32'(imem_req), 32'd0);
    check("en_off_addr", 32'(imem_addr), 32'h201);
    tick(); settle();
    check("en_captured_valid", 32'(out_valid), 32'd1);
    check("en_captured_pc", 32'(out_pc), 32'h200);
    check("en_captured_count", 32'(count), 32'd1);
    check("en_off_req2", 32'(imem_req), 32'd0);
    tick(); settle();
    check("en_frozen_addr", 32'(imem_addr), 32'h201);
    tick();
    out_ready = 1'b1;
    settle(); tick();
    out_ready = 1'b0; enable = 1'b1;
    settle();
    check("en_dequeued", 32'(count), 32'd0);
    check("en_resume_req", 32'(imem_req), 32'd1);
    check("en_resume_addr", 32'(imem_addr), 32'h201);
    tick();

    // Reset asserted mid-operation with two entries queued
    settle(); tick();
    settle(); tick();
    settle();
    check("mid_pre_count", 32'(count), 32'd2);
    reset = 1'b1;
    settle();
    check("mid_rst_req", 32'(imem_req), 32'd0);
    tick();
    reset = 1'b0;
    settle();
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_count", 32'(count), 32'd0);
    check("mid_restart_addr", 32'(imem_addr), 32'd0);
    tick(); settle();
    check("mid_discard", 32'(out_valid), 32'd0);
    tick(); settle();
    check("mid_first_pc", 32'(out_pc), 32'd0);
    check("mid_first_valid", 32'(out_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
